// File: rtl/mc_cla_adder.sv
// mc_cla_adder
//   Multi-cycle adder/subtractor. One GROUP-bit carry-lookahead slice is
//   resolved per clock, starting at the LSB slice. A WIDTH-bit operation
//   takes WIDTH/GROUP cycles in RUN. sum, cout and ovf stay unchanged until
//   the final slice completes.
//
// Ports
//   clk    sole clock, rising edge
//   rst    asynchronous reset, active low
//   start  request an operation; accepted only in IDLE or DONE
//   a, b   operands, captured when start is accepted
//   cin    carry-in for add; ignored when sub=1
//   sub    1 = a - b, computed as a + ~b + 1
//   busy   high while in RUN
//   done   one-cycle pulse; sum/cout/ovf are valid
//   sum    registered result
//   cout   carry out of bit WIDTH-1
//   ovf    signed overflow (carry into MSB xor carry out of MSB)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; result registers hold the last result
// RUN    | resolving one slice per clock; busy=1
// DONE   | result just loaded; done=1 for one cycle; start restarts
module mc_cla_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSL   = WIDTH / GROUP;
  localparam int IDX_W = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSL - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nx;

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;
  logic [GROUP-1:0] s_sl;
  logic             pp;
  logic             c_in;

  logic accept;
  logic last_slice;

  assign accept     = start && ((state == S_IDLE) || (state == S_DONE));
  assign last_slice = (state == S_RUN) && (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (start) state_nx = S_RUN;
      S_RUN:   if (idx == LAST_IDX) state_nx = S_DONE;
      S_DONE:  state_nx = start ? S_RUN : S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Lookahead slice on the low GROUP bits of the shifting operand registers.
  // Each carry is the flattened sum-of-products form:
  //   c[i+1] = g[i] | p[i]g[i-1] | p[i]p[i-1]g[i-2] | ... | p[i..0]c_in
  always_comb begin
    c_in = carry;
    g    = op_a[GROUP-1:0] & op_b[GROUP-1:0];
    p    = op_a[GROUP-1:0] ^ op_b[GROUP-1:0];
    c    = '0;
    pp   = 1'b0;
    c[0] = c_in;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      pp     = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (pp & g[j]);
        pp     = pp & p[j];
      end
      c[i+1] = c[i+1] | (pp & c_in);
    end
    s_sl = p ^ c[GROUP-1:0];
  end

  // Slice results enter at the top of the working register and shift down,
  // so after the last slice the LSB slice sits at bit 0.
  if (GROUP < WIDTH) begin : g_shift
    assign work_nx = {s_sl, work[WIDTH-1:GROUP]};
  end else begin : g_single
    assign work_nx = s_sl;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_a  <= '0;
      op_b  <= '0;
      carry <= 1'b0;
      idx   <= '0;
      work  <= '0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      op_a  <= a;
      op_b  <= sub ? ~b : b;
      carry <= sub ? 1'b1 : cin;
      idx   <= '0;
      work  <= '0;
    end else if (state == S_RUN) begin
      // Operands shift down so the next slice is always in the low bits.
      op_a  <= op_a >> GROUP;
      op_b  <= op_b >> GROUP;
      carry <= c[GROUP];
      work  <= work_nx;
      idx   <= idx + 1'b1;
      if (last_slice) begin
        sum  <= work_nx;
        cout <= c[GROUP];
        ovf  <= c[GROUP] ^ c[GROUP-1];
      end
    end
  end

endmodule

// File: tb/tb_mc_cla_adder.sv
// Self-checking bench for mc_cla_adder (WIDTH=32, GROUP=8).
// Expected results come from an arithmetic model, are queued at launch and
// compared by a monitor whenever done is seen.
module tb_mc_cla_adder;

  localparam int W = 32;
  localparam int G = 8;

  typedef logic [W+1:0] res_t;  // {ovf, cout, sum}

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
  logic         cin   = 1'b0;
  logic         sub   = 1'b0;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   n_chk  = 0;
  int   n_pass = 0;
  res_t exp_q[$];
  res_t mon_r;

  mc_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sub   (sub),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
  endtask

  function automatic res_t model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                 input logic tcin, input logic tsub);
    logic [W-1:0] bb;
    logic [W:0]   r;
    logic         ov;
    bb = tsub ? ~tb : tb;
    r  = {1'b0, ta} + {1'b0, bb} + {{W{1'b0}}, (tsub ? 1'b1 : tcin)};
    ov = (ta[W-1] == bb[W-1]) && (r[W-1] != ta[W-1]);
    return {ov, r};
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        chk("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        mon_r = exp_q.pop_front();
        chk("sum",  {32'd0, sum}, {32'd0, mon_r[W-1:0]});
        chk("cout", {63'd0, cout}, {63'd0, mon_r[W]});
        chk("ovf",  {63'd0, ovf},  {63'd0, mon_r[W+1]});
      end
    end
  end

  // Called at a negedge; returns at the next negedge with start dropped.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub);
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    exp_q.push_back(model(ta, tb, tcin, tsub));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; optionally disturbs inputs mid-RUN.
  task automatic wait_done(input string tag, input bit disturb);
    int lat;
    int busy_n;
    lat = 0;
    busy_n = 0;
    while (!done && lat < 20) begin
      if (busy) busy_n++;
      if (disturb && lat == 2) begin
        a = '0; b = $urandom; cin = 1'b1; sub = 1'b1; start = 1'b1;
      end
      if (disturb && lat == 3) start = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_busy_cycles"}, 64'(busy_n), 64'd4);
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tcin, input logic tsub, input bit disturb);
    @(negedge clk);
    launch(ta, tb, tcin, tsub);
    wait_done(tag, disturb);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
    chk({tag, "_idle_busy"}, {63'd0, busy}, 64'd0);
  endtask

  initial begin
    res_t first;
    bit   seen_done;

    // Reset state
    #2 rst = 1'b0;
    #10;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sum",  {32'd0, sum},  64'd0);
    chk("rst_cout", {63'd0, cout}, 64'd0);
    chk("rst_ovf",  {63'd0, ovf},  64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed arithmetic cases
    run_op("carry_wrap", 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    chk("carry_wrap_sum_k",  {32'd0, sum}, 64'h0);
    chk("carry_wrap_cout_k", {63'd0, cout}, 64'd1);
    run_op("pos_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
    chk("pos_ovf_sum_k", {32'd0, sum}, 64'h8000_0000);
    chk("pos_ovf_ovf_k", {63'd0, ovf}, 64'd1);
    run_op("sub_neg", 32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
    chk("sub_neg_sum_k", {32'd0, sum}, 64'hFFFF_FFFE);
    run_op("add_cin", 32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b0, 1'b0);

    // Inputs and start changing during RUN must not matter
    run_op("disturb", 32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1);
    chk("disturb_sum_k", {32'd0, sum}, 64'h0001_0000);

    // Reset mid-RUN aborts with no done afterwards
    @(negedge clk);
    launch(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_back());
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_sum",  {32'd0, sum},  64'd0);
    @(negedge clk);
    rst = 1'b1;
    seen_done = 1'b0;
    repeat (8) begin
      @(negedge clk);
      seen_done = seen_done | done;
    end
    chk("abort_no_done", {63'd0, seen_done}, 64'd0);
    run_op("post_reset", 32'd3, 32'd4, 1'b0, 1'b0, 1'b0);
    chk("post_reset_sum_k", {32'd0, sum}, 64'd7);

    // Back-to-back: start held in the DONE cycle
    @(negedge clk);
    first = model(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    launch(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    wait_done("b2b_first", 1'b0);
    launch(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
    chk("b2b_rerun_busy", {63'd0, busy}, 64'd1);
    chk("b2b_hold_sum", {32'd0, sum}, {32'd0, first[W-1:0]});
    wait_done("b2b_second", 1'b0);
    chk("b2b_sum_k",  {32'd0, sum}, 64'd0);
    chk("b2b_cout_k", {63'd0, cout}, 64'd1);
    chk("b2b_ovf_k",  {63'd0, ovf},  64'd1);
    @(negedge clk);

    // Random operations
    for (int k = 0; k < 12; k++) begin
      run_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    end

    @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mc_cla_adder.md
MC_CLA_ADDER -- requirements
Module: mc_cla_adder

Interface
REQ-001 Parameter WIDTH, default 32: operand and sum width; SHALL be a multiple of GROUP.
REQ-002 Parameter GROUP, default 8: bits resolved per cycle by the lookahead slice.
REQ-003 Port clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low.
REQ-005 Port start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-006 Port a  input  WIDTH  operand A, captured when start is accepted.
REQ-007 Port b  input  WIDTH  operand B, captured when start is accepted.
REQ-008 Port cin  input  1  carry-in for add; ignored when sub=1.
REQ-009 Port sub  input  1  1 = compute a - b as a + ~b + 1.
REQ-010 Port busy  output  1  high while the operation is in progress.
REQ-011 Port done  output  1  one-cycle pulse; result valid.
REQ-012 Port sum  output  WIDTH  registered result.
REQ-013 Port cout  output  1  carry out of bit WIDTH-1.
REQ-014 Port ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-016 In IDLE or DONE with start=1 at a clock edge, the block SHALL capture a, the B operand (b or ~b), and the carry (cin, or 1 if sub), clear the slice index, and enter RUN.
REQ-017 In RUN, each edge SHALL resolve one GROUP-bit slice, starting from the LSB slice: per bit g=a&b and p=a^b; carries c[i+1]=g[i]|(p[i]&c[i]), flattened as lookahead terms from the slice carry-in; slice sum=p^c.
REQ-018 The slice carry-out SHALL become the next slice's carry-in; the carry into the slice MSB SHALL be retained for the ovf computation.
REQ-019 Slice results SHALL accumulate in an internal working register; sum, cout, and ovf SHALL NOT change during RUN.
REQ-020 On the edge that completes slice WIDTH/GROUP-1, the block SHALL load sum, cout, and ovf from the working result, set done=1, and enter DONE.
REQ-021 Latency: with start accepted at edge E0, done SHALL be high in the cycle following edge E(WIDTH/GROUP), i.e. edge E4 at the defaults.
REQ-022 busy SHALL be 1 exactly while the state is RUN.
REQ-023 done SHALL be 1 exactly while the state is DONE; DONE SHALL last one cycle, then return to IDLE unless start=1, which SHALL re-enter RUN (back-to-back operation).
REQ-024 start SHALL be ignored in RUN; changes to a, b, cin, or sub during RUN SHALL NOT affect the result.
REQ-025 sum, cout, and ovf SHALL hold their values until the next completion.
REQ-026 Results SHALL equal {cout,sum} = a + b + cin (add) or a + ~b + 1 (sub), computed modulo 2^(WIDTH+1).

Reset
REQ-027 rst=0 SHALL immediately, without waiting for a clock edge, force the state to IDLE and force busy=0, done=0, sum=0, cout=0, ovf=0, and clear the working register and index.
REQ-028 Reset asserted during RUN SHALL abort the operation; no done pulse SHALL follow the deassertion of reset.
REQ-029 After rst returns to 1, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-030 a=0x00000001, b=0xFFFFFFFF, cin=0, sub=0 -> done 4 cycles after start; sum=0x00000000, cout=1, ovf=0.
REQ-031 a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
REQ-032 a=5, b=7, sub=1, cin=1 (ignored) -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-033 Start with a=0x0000FFFF, b=0x00000001, cin=0; pulse start and change a to 0 at cycle 2 -> only one done, sum=0x00010000, busy high for exactly 4 cycles.
REQ-034 rst=0 asserted mid-RUN at cycle 2 -> busy=0 and sum=0 at once, no done pulse; a subsequent 3+4 add -> sum=7.
REQ-035 start held high in the DONE cycle with new operands 0x80000000 + 0x80000000 -> second done 4 cycles later, sum=0, cout=1, ovf=1, first result visible until then.
